// File: rtl/prog_clock_divider.sv
`default_nettype none
//==============================================================================
// Module      : prog_clock_divider
// Description : Multi-channel programmable clock/tick generator. Every channel
//               divides clk by a run-time divisor (2 .. 2^DIV_W-1) and
//               produces a near-50% duty divided clock and a one-cycle tick at
//               the start of each period. New divisors are held pending and
//               only take effect at the channel's period boundary, so the
//               output never shows a runt or stretched pulse.
//
// Ports       : clk      - system clock
//               rst      - synchronous reset, active high
//               ena      - global advance enable (low freezes all channels)
//               sync     - one-cycle strobe, restarts running channels at phase 0
//               wr_en    - divisor write strobe
//               wr_ch    - channel index for the write (out of range ignored)
//               wr_div   - new divisor (0 stops the channel, 1 acts as 2)
//               div_clk  - registered divided clock per channel
//               tick     - registered one-cycle period-start pulse per channel
//               pend     - divisor written but not yet applied, per channel
//
// Revision    : 1.0 - initial release
//==============================================================================
module prog_clock_divider #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 27,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              sync,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    output logic [NUM_CH-1:0] div_clk,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    localparam logic [DIV_W-1:0] c_zero = '0;
    localparam logic [DIV_W-1:0] c_one  = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_two  = DIV_W'(2);

    // A divisor of 1 cannot produce both a high and a low phase, so it is
    // stored as 2. Clamping at capture time keeps the per-channel logic free
    // of a special case.
    logic [DIV_W-1:0] w_wr_div_clamped;
    assign w_wr_div_clamped = (wr_div == c_one) ? c_two : wr_div;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [CH_W-1:0] c_ch_idx = CH_W'(gi);

            logic [DIV_W-1:0] r_cnt;
            logic [DIV_W-1:0] r_dact;
            logic [DIV_W-1:0] r_dpend;
            logic             r_pend;
            logic             r_div_clk;
            logic             r_tick;

            logic             w_wr_hit;
            logic             w_apply;
            logic [DIV_W-1:0] w_cnt_nxt;
            logic [DIV_W-1:0] w_dact_nxt;
            logic [DIV_W-1:0] w_high_nxt;

            // Channel indices at or above NUM_CH never match any c_ch_idx,
            // which is what makes out-of-range writes harmless.
            assign w_wr_hit = wr_en && (wr_ch == c_ch_idx);

            // Period boundary: last count of the period, a stopped channel
            // (so a pending divisor can start it), or a global restart.
            assign w_apply = (r_dact == c_zero) ||
                             (r_cnt == (r_dact - c_one)) ||
                             sync;

            always_comb begin
                w_cnt_nxt  = r_cnt + c_one;
                w_dact_nxt = r_dact;
                if (w_apply) begin
                    w_cnt_nxt = c_zero;
                    if (r_pend) begin
                        w_dact_nxt = r_dpend;
                    end
                end
            end

            // High phase length is ceil(D/2): odd divisors get the extra cycle high.
            assign w_high_nxt = w_dact_nxt - (w_dact_nxt >> 1);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt     <= c_zero;
                    r_dact    <= c_zero;
                    r_dpend   <= c_zero;
                    r_pend    <= 1'b0;
                    r_div_clk <= 1'b0;
                    r_tick    <= 1'b0;
                end else begin
                    // Writes are captured regardless of ena. A write landing on
                    // the apply edge wins over the clear, so the freshly written
                    // value stays pending while the apply consumes the old one.
                    if (w_wr_hit) begin
                        r_dpend <= w_wr_div_clamped;
                        r_pend  <= 1'b1;
                    end else if (ena && w_apply) begin
                        r_pend  <= 1'b0;
                    end

                    if (ena) begin
                        r_cnt     <= w_cnt_nxt;
                        r_dact    <= w_dact_nxt;
                        r_div_clk <= (w_dact_nxt != c_zero) && (w_cnt_nxt < w_high_nxt);
                        r_tick    <= (w_dact_nxt != c_zero) && (w_cnt_nxt == c_zero);
                    end else begin
                        r_tick    <= 1'b0;
                    end
                end
            end

            assign div_clk[gi] = r_div_clk;
            assign tick[gi]    = r_tick;
            assign pend[gi]    = r_pend;
        end
    endgenerate

endmodule
`default_nettype wire
